// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, default latencies and FSM states for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MD_MULTU = 2'b00, MD_MULT = 2'b01, MD_DIVU = 2'b10, MD_DIV = 2'b11} mdop_t;
  typedef enum logic {MDU_IDLE, MDU_RUN} state_t;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: control/data bundle between execute stage and mdu
//   master drives start/mdop/mdwe/hilo/fhilo/a/b, slave returns busy/hi/lo/rdata
import mdu_pkg::*;
interface mdu_if;
  logic start;
  mdop_t mdop;
  logic mdwe;
  logic hilo;
  logic fhilo;
  logic [31:0] a;
  logic [31:0] b;
  logic busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  modport master(output start, mdop, mdwe, hilo, fhilo, a, b, input busy, hi, lo, rdata);
  modport slave(input start, mdop, mdwe, hilo, fhilo, a, b, output busy, hi, lo, rdata);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: combinational 64-bit {hi,lo} result for mult/multu/div/divu
//   a, b: latched operands; op: operation; res: {hi,lo}; div_by_zero: divide with b==0
import mdu_pkg::*;
module mdu_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdop_t       op,
  output logic [63:0] res,
  output logic        div_by_zero
);
  logic sgn, na, nb;
  logic [63:0] prod;
  logic [31:0] ua, ub, q, r;
  always_comb begin
    sgn = op[0];
    na = sgn & a[31];
    nb = sgn & b[31];
    // low 64 bits of the product of extended operands equal the signed/unsigned product
    prod = {{32{na}}, a} * {{32{nb}}, b};
    // divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0 naturally
    ua = na ? -a : a;
    ub = nb ? -b : b;
    div_by_zero = op[1] & (b == '0);
    q = (ub == '0) ? '0 : ua / ub;
    r = (ub == '0) ? '0 : ua % ub;
    res = op[1] ? {na ? -r : r, (na ^ nb) ? -q : q} : prod;
  end
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO
//   clk, reset (async active-high); bus: start/mdop/mdwe/hilo/fhilo/a/b in, busy/hi/lo/rdata out
import mdu_pkg::*;
module mdu #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  state_t state;
  logic busy, dz;
  logic [7:0] cnt;
  logic [31:0] op_a, op_b, hi, lo;
  mdop_t op;
  logic [63:0] res;
  mdu_core core (.a(op_a), .b(op_b), .op(op), .res(res), .div_by_zero(dz));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= MDU_IDLE;
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      op_a <= '0;
      op_b <= '0;
      op <= MD_MULTU;
    end else if (state == MDU_IDLE) begin
      if (bus.start) begin
        op_a <= bus.a;
        op_b <= bus.b;
        op <= bus.mdop;
        cnt <= bus.mdop[1] ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
        state <= MDU_RUN;
        busy <= 1'b1;
      end else if (bus.mdwe) begin
        if (bus.hilo) hi <= bus.a;
        else lo <= bus.a;
      end
    end else begin
      cnt <= cnt - 8'd1;
      if (cnt == 8'd1) begin
        if (!dz) {hi, lo} <= res;
        state <= MDU_IDLE;
        busy <= 1'b0;
      end
    end
  assign bus.busy = busy;
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.rdata = bus.fhilo ? hi : lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu with directed vectors
import mdu_pkg::*;
module tb_mdu;
  typedef struct {
    int id;
    int len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  logic clk, reset;
  mdu_if bus ();
  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int next_id = 0;
  int run_len = 0;
  logic prev_busy = 1'b0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1) run_len++;
    else if (prev_busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got busy fall with len %0d want none", run_len);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_len", e.id), 32'(run_len), 32'(e.len));
        chk($sformatf("op%0d_hi", e.id), bus.hi, e.hi);
        chk($sformatf("op%0d_lo", e.id), bus.lo, e.lo);
      end
      run_len = 0;
    end
    prev_busy = bus.busy;
  end
  task automatic run_op(input mdop_t op, input logic [31:0] x, input logic [31:0] y, input int len,
                        input logic [31:0] eh, input logic [31:0] el, input bit disturb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdop = op;
    bus.a = x;
    bus.b = y;
    bus.mdwe = disturb;
    bus.hilo = 1'b1;
    sb.push_back('{next_id, len, eh, el});
    next_id++;
    @(negedge clk);
    bus.start = disturb;
    bus.mdwe = disturb;
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
      if (disturb) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.mdop = MD_DIV;
        bus.hilo = i[0];
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mdwe = 1'b0;
    if (bus.busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL op%0d_timeout: got busy %b want 0", next_id - 1, bus.busy);
    end
  endtask
  task automatic mtx(input logic h, input logic [31:0] v);
    @(negedge clk);
    bus.mdwe = 1'b1;
    bus.hilo = h;
    bus.a = v;
    @(negedge clk);
    bus.mdwe = 1'b0;
    chk(h ? "mthi" : "mtlo", h ? bus.hi : bus.lo, v);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mdop = MD_MULTU;
    bus.mdwe = 1'b0;
    bus.hilo = 1'b0;
    bus.fhilo = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b0;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op(MD_MULTU, 32'hFFFFFFFD, 32'd7, 5, 32'h00000006, 32'hFFFFFFEB, 1'b0);
    run_op(MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);
    mtx(1'b1, 32'h11);
    mtx(1'b0, 32'h22);
    run_op(MD_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b0);
    mtx(1'b1, 32'hABCD);
    bus.fhilo = 1'b1;
    #1 chk("rdata_hi", bus.rdata, 32'hABCD);
    bus.fhilo = 1'b0;
    #1 chk("rdata_lo", bus.rdata, 32'h22);
    run_op(MD_MULT, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdop = MD_DIV;
    bus.a = 32'd100;
    bus.b = 32'd3;
    sb.push_back('{next_id, 3, 32'd0, 32'd0});
    next_id++;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op(MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage. It consumes the `start`, `mdop`, `mdwe`, `hilo` and `fhilo` controls decoded for `mult/multu/div/divu/mthi/mtlo/mfhi/mflo`. It owns the architectural HI/LO registers and drives `busy` back to the hazard unit, which stalls any HI/LO-touching instruction while an operation is in flight. It also returns HI or LO data for the `mfhi`/`mflo` writeback mux.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: launch an operation this cycle.
- `mdop` in 2: operation select: 00 `multu`, 01 `mult`, 10 `divu`, 11 `div`.
- `mdwe` in 1: direct HI/LO write (`mthi`/`mtlo`).
- `hilo` in 1: direct-write target: 1 HI, 0 LO.
- `fhilo` in 1: read select: 1 HI, 0 LO.
- `a` in 32: rs operand, or write data for `mdwe`.
- `b` in 32: rt operand.
- `busy` out 1: operation in flight.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `rdata` out 32: `fhilo ? hi : lo`, combinational.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter `cnt` active.
- IDLE with `start`=1:
  - Latch `a`, `b` and `mdop`.
  - Load `cnt` with `MULT_CYCLES` when `mdop[1]`=0, otherwise `DIV_CYCLES`.
  - Go to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - On the cycle `cnt`=1, commit the pending result to HI/LO and return to IDLE.
- Arithmetic, on the latched operands:
  - `mult`: signed 32x32→64; HI=upper, LO=lower.
  - `multu`: unsigned 32x32→64.
  - `div`: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - `divu`: unsigned quotient and remainder.
  - `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (`b`=0):
  - Full `DIV_CYCLES` busy period still runs.
  - HI/LO are left unchanged at commit.
- Direct write: `mdwe`=1 in IDLE with `start`=0 writes `a` into HI (`hilo`=1) or LO (`hilo`=0) at the next edge.
- Simultaneous events:
  - `start` and `mdwe` together: `start` wins; `mdwe` is ignored.
  - `start` or `mdwe` while RUN: ignored. The hazard unit prevents this; the block still must not corrupt state.
  - The latched operands must not change mid-operation.
- `rdata` shows the current registers. During RUN it shows the pre-operation values; the hazard unit stalls `mfhi`/`mflo` until `busy` falls.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `cnt`=0, state IDLE. Any pending result is discarded.
- Reset asserted mid-operation aborts it immediately.
- Operation latency, with `start` sampled at edge T:
  - `busy`=1 during cycles T+1 … T+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO hold the new result and `busy`=0 from cycle T+N+1.
- Back-to-back: a new `start` is accepted in cycle T+N+1 and may read the just-committed HI/LO.
- Direct-write latency: `mdwe` at edge T makes the new value visible on `hi`/`lo`/`rdata` in cycle T+1.
- `busy` is a register output, glitch-free, with no combinational path from the inputs.

## Structure
- Shared package `mdu_pkg`:
  - `mdop` encodings `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`.
  - Default latency constants.
  - State enum `{MDU_IDLE, MDU_RUN}`.
- One sub-module, `mdu_core`: purely combinational 64-bit result from the latched operands and `mdop`, plus a `div_by_zero` flag. The FSM, counter and HI/LO registers stay in `mdu`.

## Test plan
- Reset: reset, then `mult` `a`=0xFFFFFFFD `b`=7. `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Unsigned and divide: `multu` with the same operands → HI=0x00000006, LO=0xFFFFFFEB. `divu` 7/2 → `busy` 10 cycles, LO=3, HI=1.
- Signed divide: `div` 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. `div` 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22, then `divu` x/0 → `busy` 10 cycles, HI/LO still 0x11/0x22.
- Direct write vs busy: `mthi` 0xABCD in IDLE → `hi`=0xABCD next cycle, `rdata`=0xABCD with `fhilo`=1. During a `mult` busy period, `start`/`mdwe` pulses have no effect on HI/LO, the busy length or the result.
- Reset mid-operation: reset at cycle 3 of a `div` → `busy`, `hi`, `lo` = 0 immediately. A subsequent `mult` 6×7 → LO=42, HI=0.
